// File: rtl/reaction_timer.sv
// Reaction-time controller: pseudo-random pre-delay, LED stimulus, tick counting,
// and load/clear strobes (d/en/clr) for the downstream result register.
module reaction_timer #(
  parameter int N         = 16,
  parameter int TICK_DIV  = 100000,
  parameter int DELAY_MIN = 1000,
  parameter int RAND_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  output logic         led,
  output logic         busy,
  output logic         early,
  output logic [N-1:0] d,
  output logic         en,
  output logic         clr
);
  localparam int PW        = $clog2(TICK_DIV);
  localparam int DELAY_MAX = DELAY_MIN + (1 << RAND_BITS) - 1;
  localparam int DW        = $clog2(DELAY_MAX + 1);

  localparam logic [N-1:0]  CNT_MAX    = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0]  CNT_LAST   = CNT_MAX - N'(1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DELAY_BASE = DW'(DELAY_MIN);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          start_q, stop_q;
  logic          rise_start, rise_stop, tick;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc, presc_n;
  logic [DW-1:0] delay, delay_n;
  logic [N-1:0]  count, count_n, d_n;
  logic          early_n, en_n, clr_n;

  assign rise_start = start & ~start_q;
  assign rise_stop  = stop & ~stop_q;
  assign tick       = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = tick ? '0 : presc + PW'(1);
    delay_n = delay;
    count_n = count;
    d_n     = d;
    early_n = early;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    case (state)
      S_IDLE: begin
        // A simultaneous stop rise is ignored here, so start wins.
        if (rise_start) begin
          state_n = S_WAIT;
          delay_n = DELAY_BASE + DW'(lfsr[RAND_BITS-1:0]);
          d_n     = '0;
          early_n = 1'b0;
          en_n    = 1'b1;
          clr_n   = 1'b1;
        end
      end
      S_WAIT: begin
        if (rise_stop) begin
          state_n = S_IDLE;
          d_n     = '1;
          early_n = 1'b1;
          en_n    = 1'b1;
        end else if (tick) begin
          if (delay <= DW'(1)) begin
            state_n = S_RUN;
            count_n = '0;
          end else begin
            delay_n = delay - DW'(1);
          end
        end
      end
      S_RUN: begin
        // Stop reports the pre-increment count even when it meets a tick.
        if (rise_stop) begin
          state_n = S_IDLE;
          d_n     = count;
          en_n    = 1'b1;
        end else if (tick) begin
          if (count == CNT_LAST) begin
            state_n = S_IDLE;
            count_n = CNT_MAX;
            d_n     = CNT_MAX;
            en_n    = 1'b1;
          end else begin
            count_n = count + N'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Restart the prescaler so the first tick lands TICK_DIV cycles after entry.
    if ((state_n != state) && (state_n != S_IDLE)) begin
      presc_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      lfsr    <= LFSR_SEED;
      presc   <= '0;
      delay   <= '0;
      count   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      early   <= 1'b0;
      d       <= '0;
      en      <= 1'b0;
      clr     <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      presc   <= presc_n;
      delay   <= delay_n;
      count   <= count_n;
      led     <= (state_n == S_RUN);
      busy    <= (state_n != S_IDLE);
      early   <= early_n;
      d       <= d_n;
      en      <= en_n;
      clr     <= clr_n;
    end
  end
endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: time-based reference model, per-cycle output compare,
// en-event expected queue, directed scenarios and a randomized phase.
module tb_reaction_timer;
  localparam int N         = 8;
  localparam int TICK_DIV  = 4;
  localparam int DELAY_MIN = 3;
  localparam int RAND_BITS = 2;
  localparam int W         = N + 1;
  localparam int RUN_LIMIT = (1 << N) - 2;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         led, busy, early, en, clr;
  logic [N-1:0] d;

  int checks = 0;
  int errors = 0;

  reaction_timer #(
    .N(N), .TICK_DIV(TICK_DIV), .DELAY_MIN(DELAY_MIN), .RAND_BITS(RAND_BITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .led(led), .busy(busy), .early(early), .d(d), .en(en), .clr(clr)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  // reference model: phase + edge timestamps; ticks fall every TICK_DIV edges after entry
  int           ph      = 0;
  int           edge_n  = 0;
  int           t_entry = 0;
  int           dly     = 0;
  int           el      = 0;
  logic [15:0]  m_lfsr  = 16'hACE1;
  logic         p_start = 1'b0, p_stop = 1'b0, m_rs, m_rp;
  logic         m_led = 1'b0, m_busy = 1'b0, m_early = 1'b0, m_en = 1'b0, m_clr = 1'b0;
  logic [N-1:0] m_d = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_ev;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      ph = 0; p_start = 1'b0; p_stop = 1'b0; m_lfsr = 16'hACE1;
      m_led = 1'b0; m_busy = 1'b0; m_early = 1'b0; m_en = 1'b0; m_clr = 1'b0; m_d = '0;
      exp_q.delete();
    end else begin
      m_rs  = start & ~p_start;
      m_rp  = stop & ~p_stop;
      m_en  = 1'b0;
      m_clr = 1'b0;
      el    = edge_n - t_entry;
      if (ph == 0) begin
        if (m_rs) begin
          ph = 1; t_entry = edge_n;
          dly = DELAY_MIN + (int'(m_lfsr) % (1 << RAND_BITS));
          m_early = 1'b0; m_d = '0; m_en = 1'b1; m_clr = 1'b1;
        end
      end else if (ph == 1) begin
        if (m_rp) begin
          ph = 0; m_d = '1; m_early = 1'b1; m_en = 1'b1;
        end else if ((el % TICK_DIV == 0) && (el / TICK_DIV >= dly)) begin
          ph = 2; t_entry = edge_n;
        end
      end else begin
        if (m_rp) begin
          ph = 0; m_d = N'((el - 1) / TICK_DIV); m_en = 1'b1;
        end else if ((el % TICK_DIV == 0) && (el / TICK_DIV >= RUN_LIMIT)) begin
          ph = 0; m_d = N'(RUN_LIMIT); m_en = 1'b1;
        end
      end
      if (m_en) exp_q.push_back({m_clr, m_d});
      m_led   = (ph == 2);
      m_busy  = (ph != 0);
      p_start = start;
      p_stop  = stop;
      m_lfsr  = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      edge_n++;
    end
  end

  // scoreboard: every output every cycle, plus each en event against the queue
  initial forever begin
    @(negedge clk);
    checks++;
    if ({led, busy, early, en, clr, d} !== {m_led, m_busy, m_early, m_en, m_clr, m_d}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got led=%b busy=%b early=%b en=%b clr=%b d=%h want led=%b busy=%b early=%b en=%b clr=%b d=%h",
               $time, led, busy, early, en, clr, d, m_led, m_busy, m_early, m_en, m_clr, m_d);
    end
    if (en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL en_event t=%0t got clr=%b d=%h want no event", $time, clr, d);
      end else begin
        exp_ev = exp_q.pop_front();
        if ({clr, d} !== exp_ev) begin
          errors++;
          $display("FAIL en_event t=%0t got clr/d=%h want %h", $time, {clr, d}, exp_ev);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic wait_led(input string name, input int budget, output int waited);
    waited = 0;
    while (led !== 1'b1 && waited < budget) begin
      cyc(1);
      waited++;
    end
    chk(name, 32'(led), 1);
  endtask

  initial begin
    int k;
    // reset with both buttons held high
    rst = 1'b0; start = 1'b1; stop = 1'b1;
    cyc(3);
    chk("reset_outputs", 32'({led, busy, early, en, clr, d}), 0);
    rst = 1'b1;
    cyc(1);
    chk("reset_release_start", 32'({busy, clr, en}), 32'b111);
    cyc(1);
    chk("reset_release_once", 32'({busy, clr, en}), 32'b100);
    start = 1'b0; stop = 1'b0;
    wait_led("t1_led", 40, k);
    cyc(2); press_stop();
    chk("t1_stop_en", 32'(en), 1);

    // stop 5 ticks into RUN
    press_start();
    chk("t2_clear", 32'({clr, en, busy, early}), 32'b1110);
    wait_led("t2_led", 40, k);
    cyc(21); press_stop();
    chk("t2_d", 32'(d), 5);
    chk("t2_flags", 32'({en, led, busy, early}), 32'b1000);
    cyc(1);
    chk("t2_en_once", 32'({en, d}), 5);

    // false start 2 ticks into WAIT
    press_start();
    cyc(8); press_stop();
    chk("t3_false_d", 32'(d), 32'hFF);
    chk("t3_flags", 32'({en, clr, early, led, busy}), 32'b10100);
    cyc(1);
    chk("t3_en_once", 32'(en), 0);
    press_start();
    chk("t3_restart", 32'({clr, en, early, busy}), 32'b1101);

    // timeout with no stop, then a late stop is ignored
    wait_led("t4_led", 40, k);
    k = 0;
    while (en !== 1'b1 && k < 1100) begin
      cyc(1);
      k++;
    end
    chk("t4_timeout_cycles", 32'(k), 1016);
    chk("t4_timeout_d", 32'(d), 32'hFE);
    chk("t4_flags", 32'({en, led, busy}), 32'b100);
    cyc(1);
    chk("t4_en_once", 32'(en), 0);
    press_stop();
    chk("t4_late_stop", 32'({en, busy, d}), 32'hFE);

    // start ignored in RUN; stop coinciding with the 3rd tick
    press_start();
    wait_led("t5_led", 40, k);
    cyc(4); press_start();
    chk("t5_start_ignored", 32'({led, busy, en, clr, d}), 32'b1100_0000_0000);
    cyc(6); press_stop();
    chk("t5_d", 32'({en, d}), 32'h102);

    // reset mid-RUN, then a fresh start
    press_start();
    wait_led("t6_led", 40, k);
    cyc(7);
    rst = 1'b0;
    #1;
    chk("t6_reset_now", 32'({led, busy, early, en, clr, d}), 0);
    cyc(3); rst = 1'b1; cyc(2);
    chk("t6_idle", 32'({led, busy, en}), 0);
    press_start();
    chk("t6_start", 32'({clr, en, busy}), 32'b111);
    wait_led("t6_led2", 40, k);
    chk("t6_delay_range", 32'((k >= 12) && (k <= 24) && (k % 4 == 0)), 1);
    cyc(5); press_stop();
    chk("t6_d", 32'({en, d}), 32'h101);

    // randomized button activity
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      cyc(1);
    end
    start = 1'b0; stop = 1'b0;
    cyc(4);
    chk("queue_drained", 32'(exp_q.size()), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Reaction-time measurement controller for the timing test design.
- On a start press it waits a pseudo-random delay, then lights an LED and counts milliseconds until the stop press.
- It drives d/en/clr directly into the downstream N-bit capture register (enable, sync clear, async reset) that holds the displayed result.
- Inputs start/stop are already debounced and synchronous to clk.

Parameters:
- N, 16, result/counter width; must match the downstream register width.
- TICK_DIV, 100000, clk cycles per count tick (1 ms at 100 MHz); must be >= 2.
- DELAY_MIN, 1000, minimum wait in ticks before the LED lights.
- RAND_BITS, 10, width of the random extra delay (0 .. 2^RAND_BITS-1 ticks).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  debounced start button level.
- stop  in  1  debounced stop button level.
- led  out  1  stimulus LED; high only in RUN.
- busy  out  1  high in WAIT or RUN.
- early  out  1  set on a false start; cleared on the next accepted start.
- d  out  N  result word to the downstream register.
- en  out  1  one-cycle load/clear strobe to the downstream register.
- clr  out  1  one-cycle clear request; always asserted together with en.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; led, busy, early, en, clr = 0; d = 0.
  - Prescaler, tick and delay counters = 0.
  - LFSR = 16'hACE1.
- Edge detect:
  - Registered copies start_q and stop_q.
  - rise_x = x & ~x_q.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-running every clk from reset; never all-zero.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and pulses tick when it equals TICK_DIV-1.
  - Prescaler is forced to 0 on entry to WAIT and to RUN, so the first tick comes exactly TICK_DIV cycles after entry.
- All outputs are registered. An event detected in cycle k produces its output in cycle k+1.
- IDLE:
  - On rise_start: go to WAIT; busy=1; early=0; emit clr=1, en=1 for one cycle (clears the downstream register).
  - Load delay = DELAY_MIN + LFSR[RAND_BITS-1:0].
  - rise_stop is ignored.
  - If rise_start and rise_stop occur together, start wins.
- WAIT:
  - Each tick decrements delay. A tick with delay==1 (or delay==0) moves to RUN: led=1, count=0.
  - On rise_stop (false start): go to IDLE; d = all ones; en=1 for one cycle, clr=0; early=1; busy=0.
  - A false start takes priority over a same-cycle tick transition to RUN.
- RUN:
  - Each tick increments count, saturating at 2^N-2. The all-ones value is reserved for false start.
  - On rise_stop: go to IDLE; d=count; en=1 for one cycle; led=0; busy=0.
  - If rise_stop and a tick coincide, d = count before the increment.
  - Timeout: when count reaches 2^N-2 on a tick, go to IDLE with d=2^N-2, en=1, led=0.
- rise_start in WAIT or RUN is ignored.
- en is high for exactly one cycle per event. clr is high only in the IDLE→WAIT cycle.
- d holds its value until the next en event.
- Reset mid-operation aborts immediately to the reset values. No en is emitted.

Test Plan:
- Use N=8, TICK_DIV=4, DELAY_MIN=3, RAND_BITS=2.
- Reset with start/stop high -> all outputs 0; no spurious rise after rst deasserts with inputs held high (start_q/stop_q reset to 0 → one rise expected; bench confirms WAIT is entered and clr=en=1 for exactly one cycle).
- Start pulse, wait for led, stop rise after exactly 5 ticks in RUN -> en one cycle with d=8'd5, led falls with en, busy=0, early=0.
- Stop rise 2 ticks into WAIT -> d=8'hFF, en one cycle, clr=0, early=1, led never asserted; next start -> clr=en=1, early=0.
- Start then no stop -> after 254 ticks in RUN: d=8'hFE, en one cycle, IDLE; extra stop rise afterwards -> no en.
- Stop rise in the same cycle as the 3rd RUN tick -> d=8'd2; start rises during RUN ignored (d, led unaffected).
- Assert rst low mid-RUN -> led, busy, en, d immediately 0; after release, IDLE, and a fresh start works with delay in 3..6 ticks.
